// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial adder:
//     DEFAULT_WIDTH - default operand/result width in bits
//     state_e       - controller states IDLE / SHIFT / DONE
// -----------------------------------------------------------------------------
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage : serial_adder_pkg

// File: rtl/half_adder.sv
// -----------------------------------------------------------------------------
// half_adder
//   One-bit half adder. Two of these plus an OR form a full adder.
//   Ports:
//     A, B : input  addend bits
//     S    : output sum bit   (A ^ B)
//     C    : output carry bit (A & B)
// -----------------------------------------------------------------------------
module half_adder (
   input  logic A,
   input  logic B,
   output logic S,
   output logic C
);

   assign S = A ^ B;
   assign C = A & B;

endmodule : half_adder

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial unsigned adder. On an accepted start the operands are latched
//   and one bit per cycle is added LSB first, the result bit being shifted in
//   at the sum MSB so that after WIDTH cycles sum holds the full result.
//   done pulses for one cycle, WIDTH+1 cycles after the accepting edge.
//
//   Optional feature: define SERIAL_ADDER_SUB_EN to add the 'sub' input.
//   With sub=1 the block computes a - b as a + ~b + 1; cout=1 means no borrow.
//
//   Parameters:
//     WIDTH : operand and result width, 2..32 (default 8)
//   Ports:
//     clk   : input  rising-edge clock
//     rst_n : input  asynchronous active-low reset
//     start : input  begin an operation with current a/b (ignored while busy)
//     a, b  : input  [WIDTH-1:0] unsigned operands
//     sub   : input  subtract select (only with SERIAL_ADDER_SUB_EN)
//     busy  : output high while bits are being processed
//     done  : output one-cycle pulse, result valid
//     sum   : output [WIDTH-1:0] result (shift contents visible while busy)
//     cout  : output final carry-out (borrow-not when subtracting)
// -----------------------------------------------------------------------------
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int              CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // Operand b and carry preset as loaded on an accepted start. Subtraction
   // is folded in here, so the shift datapath itself only ever adds.
   logic [WIDTH-1:0]   b_load;
   logic               carry_load;

`ifdef SERIAL_ADDER_SUB_EN
   assign b_load     = sub ? ~b : b;
   assign carry_load = sub;
`else
   assign b_load     = b;
   assign carry_load = 1'b0;
`endif

   // Per-bit full adder: two half adders plus an OR of their carries.
   logic ha0_s, ha0_c;
   logic bit_sum, ha1_c;
   logic bit_carry;

   half_adder u_ha0 (
      .A (a_q[0]),
      .B (b_q[0]),
      .S (ha0_s),
      .C (ha0_c)
   );

   half_adder u_ha1 (
      .A (ha0_s),
      .B (carry_q),
      .S (bit_sum),
      .C (ha1_c)
   );

   assign bit_carry = ha0_c | ha1_c;

   // NOTE: every variable gets a default before the case so that no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = b_load;
               carry_d = carry_load;
               cnt_d   = '0;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end

         SHIFT: begin
            sum_d   = {bit_sum, sum_q[WIDTH-1:1]};
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = bit_carry;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: the operand shift registers are reset along with everything else;
   // sum and cout are visible outputs and must read 0 straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         // NOTE: non-blocking updates so every register samples the values
         // from before this edge, independent of statement order.
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   // The carry register is held outside SHIFT, so it doubles as cout.
   assign cout = carry_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Self-checking bench for serial_adder (WIDTH=8). Expected results come from
//   plain integer arithmetic and are queued when a start is accepted; a monitor
//   pops and compares on every done pulse. Define SERIAL_ADDER_SUB_EN for both
//   the bench and the RTL to exercise subtraction.
// -----------------------------------------------------------------------------
module tb_serial_adder;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      string        tag;
   } result_t;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub_sel;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int n_checks = 0;
   int n_pass   = 0;
   int done_cnt = 0;
   result_t exp_q[$];

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub_sel),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: true (W+1)-bit result of a+b or a-b as a + ~b + 1.
   function automatic result_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic s, input string tag);
      longint unsigned full;
      longint unsigned mask;
      result_t r;
      mask = (64'd1 << W) - 1;
      if (s) full = longint'(x) + ((~longint'(y)) & mask) + 1;
      else   full = longint'(x) + longint'(y);
      r.sum  = W'(full & mask);
      r.cout = full[W];
      r.tag  = tag;
      return r;
   endfunction

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         result_t r;
         done_cnt++;
         check("pending_result", 64'(exp_q.size() > 0), 64'd1);
         if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            check({r.tag, "_sum"},  64'(sum),  64'(r.sum));
            check({r.tag, "_cout"}, 64'(cout), 64'(r.cout));
         end
      end
   end

   // Count cycles after an accepting edge until done; bounded.
   task automatic wait_done(output int lat, output int busy_cycles);
      lat = 0;
      busy_cycles = 0;
      for (int i = 0; i < 4 * W + 8; i++) begin
         @(negedge clk);
         lat++;
         if (busy) busy_cycles++;
         if (done) break;
      end
   endtask

   // Issue one operation, scramble the inputs after latching, check timing.
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic s, input string tag, input bit chk_timing);
      int lat, bc;
      @(negedge clk);
      a = x; b = y; sub_sel = s; start = 1'b1;
      @(posedge clk);
      exp_q.push_back(model(x, y, s, tag));
      #1;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); sub_sel = 1'($urandom);
      wait_done(lat, bc);
      if (chk_timing) begin
         check({tag, "_latency"}, 64'(lat), 64'(W + 1));
         check({tag, "_busy_cycles"}, 64'(bc), 64'(W));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, bc, d0;
      logic [W-1:0] ra, rb;
      logic         rs;

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sub_sel = 1'b0;
      #12;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_sum",  64'(sum),  64'd0);
      check("reset_cout", 64'(cout), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed additions.
      run_op(8'h5A, 8'h3C, 1'b0, "add_5a_3c", 1'b1);
      run_op(8'hFF, 8'h01, 1'b0, "add_ff_01", 1'b1);
      run_op(8'h00, 8'h00, 1'b0, "add_00_00", 1'b1);

      // Result must stay stable while idle.
      repeat (3) @(negedge clk);
      check("idle_hold_sum",  64'(sum),  64'h00);
      check("idle_hold_busy", 64'(busy), 64'd0);

      // start during busy is ignored: exactly one done, original result.
      d0 = done_cnt;
      @(negedge clk);
      a = 8'h5A; b = 8'h3C; sub_sel = 1'b0; start = 1'b1;
      @(posedge clk);
      exp_q.push_back(model(8'h5A, 8'h3C, 1'b0, "ignore_start"));
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      a = 8'h11; b = 8'h22; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, bc);
      repeat (W + 4) @(negedge clk);
      check("ignore_start_done_count", 64'(done_cnt - d0), 64'd1);

      // Reset in the middle of SHIFT aborts with no done pulse.
      d0 = done_cnt;
      @(negedge clk);
      a = 8'hC3; b = 8'h5F; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_sum",  64'(sum),  64'd0);
      check("abort_cout", 64'(cout), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (W + 4) @(negedge clk);
      check("abort_no_done", 64'(done_cnt - d0), 64'd0);
      run_op(8'h01, 8'h02, 1'b0, "after_reset", 1'b1);

      // Back-to-back: start held through DONE.
      @(negedge clk);
      a = 8'h80; b = 8'h80; sub_sel = 1'b0; start = 1'b1;
      @(posedge clk);
      exp_q.push_back(model(8'h80, 8'h80, 1'b0, "b2b_first"));
      wait_done(lat, bc);
      check("b2b_first_latency", 64'(lat), 64'(W + 1));
      @(posedge clk);
      exp_q.push_back(model(8'h80, 8'h80, 1'b0, "b2b_second"));
      #1 start = 1'b0;
      @(negedge clk);
      check("b2b_restart_busy", 64'(busy), 64'd1);
      lat = 1;
      for (int i = 0; i < 4 * W; i++) begin
         if (done) break;
         @(negedge clk);
         lat++;
      end
      check("b2b_second_latency", 64'(lat), 64'(W + 1));

`ifdef SERIAL_ADDER_SUB_EN
      run_op(8'h10, 8'h01, 1'b1, "sub_10_01", 1'b1);
      run_op(8'h01, 8'h02, 1'b1, "sub_01_02", 1'b1);
`endif

      // Randomized operations.
      for (int i = 0; i < 24; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
         rs = 1'($urandom_range(0, 1));
`else
         rs = 1'b0;
`endif
         run_op(ra, rb, rs, $sformatf("rand%0d", i), (i % 4) == 0);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_serial_adder

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  request to begin an operation with the current a/b.
REQ-005 SHALL have port a  input  WIDTH  first operand, unsigned.
REQ-006 SHALL have port b  input  WIDTH  second operand, unsigned.
REQ-007 SHALL have port busy  output  1  high while bits are being processed.
REQ-008 SHALL have port done  output  1  single-cycle pulse, result valid.
REQ-009 SHALL have port sum  output  WIDTH  result, LSB first assembled.
REQ-010 SHALL have port cout  output  1  final carry-out (borrow-not in subtract mode).

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-012 SHALL, on an edge with start=1 in IDLE or DONE, latch a and b into shift registers, clear bit counter, set carry register to 0 (1 when subtracting), and enter SHIFT.
REQ-013 SHALL, in each SHIFT cycle, add operand LSBs plus carry register, shift result bit into sum MSB, shift operands right, update carry, increment counter.
REQ-014 SHALL leave SHIFT for DONE after exactly WIDTH SHIFT cycles (counter reaches WIDTH-1).
REQ-015 SHALL assert done for exactly the one cycle spent in DONE, then go to IDLE unless start=1.
REQ-016 Latency: done high in the (WIDTH+1)th cycle after the start-accepting edge.
REQ-017 SHALL hold sum and cout stable from DONE until the next accepted start; sum/cout undefined-free (intermediate shift contents visible) while busy.
REQ-018 SHALL assert busy iff state is SHIFT.
REQ-019 SHALL ignore start while busy; in-flight operands unaffected by a/b changes after latching.
REQ-020 SHALL accept start in DONE (back-to-back); done still pulses that cycle.
REQ-021 cout SHALL equal bit WIDTH of the (WIDTH+1)-bit true sum; wrap-around of sum modulo 2^WIDTH.

Reset
REQ-022 SHALL, on rst_n low, asynchronously force state IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry=0.
REQ-023 SHALL abort any in-flight operation on reset with no done pulse; first start after release behaves as from power-up.

Configuration
REQ-024 SHALL, when SERIAL_ADDER_SUB_EN is defined, add input port sub (1 bit), latched with operands; sub=1 computes a-b as a + ~b + 1 (carry preset 1, b bits inverted), cout=1 meaning no borrow.
REQ-025 SHALL, without SERIAL_ADDER_SUB_EN, have no sub port and perform addition only, carry preset 0.

Structure
REQ-026 SHALL place state enum (IDLE/SHIFT/DONE) and default WIDTH constant in package serial_adder_pkg.
REQ-027 SHALL form the per-bit full adder from two instances of the existing half_adder (A,B,S,C) plus an OR of carries; no other sub-module.

Verification
REQ-028 WIDTH=8, a=0x5A, b=0x3C, start 1 cycle -> done in 9th cycle, sum=0x96, cout=0, busy high 8 cycles.
REQ-029 a=0xFF, b=0x01 -> sum=0x00, cout=1; a=0x00, b=0x00 -> sum=0x00, cout=0.
REQ-030 start pulsed with a=0x11 during busy of a 0x5A+0x3C run -> ignored, result 0x96, single done.
REQ-031 rst_n low at SHIFT cycle 4 -> all outputs 0 immediately, no done; next start 0x01+0x02 -> sum=0x03.
REQ-032 start held high through DONE with a=0x80, b=0x80 -> done pulses, next op starts, second done gives sum=0x00, cout=1.
REQ-033 With SERIAL_ADDER_SUB_EN: sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1; a=0x01, b=0x02 -> sum=0xFF, cout=0.
